// File: rtl/decrement_counter.sv
`default_nettype none
// ============================================================================
// Module   : decrement_counter
// Brief    : Loadable down-counter with variable step, one-shot or periodic
//            reload operation, and done/underflow/zero status flags.
// Revision : 1.0 - initial release
// ============================================================================
module decrement_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              start,
    input  logic              stop,
    input  logic              en,
    input  logic [STEP_W-1:0] step,
    input  logic              auto_reload,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              underflow,
    output logic              zero
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_done;
    logic             r_underflow;

    logic [WIDTH-1:0] w_step_ext;
    logic [WIDTH-1:0] w_eff_count;

    assign w_step_ext  = WIDTH'(step);
    // A start in the same cycle as a load must see the value being loaded.
    assign w_eff_count = load ? load_val : r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_idle;
            r_count     <= '0;
            r_reload    <= '0;
            r_done      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_underflow <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (load) begin
                        r_count  <= load_val;
                        r_reload <= load_val;
                    end
                    if (start) begin
                        if (w_eff_count != '0) begin
                            r_state <= c_run;
                        end else begin
                            r_state <= c_done;
                            r_done  <= 1'b1;
                        end
                    end
                end
                c_run: begin
                    if (load) begin
                        r_count  <= load_val;
                        r_reload <= load_val;
                    end else if (stop) begin
                        r_state <= c_idle;
                    end else if (en && (w_step_ext != '0)) begin
                        if (w_step_ext < r_count) begin
                            r_count <= r_count - w_step_ext;
                        end else begin
                            r_underflow <= (w_step_ext > r_count);
                            r_done      <= 1'b1;
                            // A zero reload value would re-fire every tick, so finish instead.
                            if (auto_reload && (r_reload != '0)) begin
                                r_count <= r_reload;
                            end else begin
                                r_count <= '0;
                                r_state <= c_done;
                            end
                        end
                    end
                end
                c_done: begin
                    if (load) begin
                        r_count  <= load_val;
                        r_reload <= load_val;
                    end
                    r_state <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign count     = r_count;
    assign busy      = (r_state == c_run);
    assign done      = r_done;
    assign underflow = r_underflow;
    assign zero      = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_decrement_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_decrement_counter
// Brief    : Scenario testbench for decrement_counter (WIDTH=8, STEP_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decrement_counter;

    typedef struct packed {
        logic [7:0] cnt;
        logic       busy;
        logic       done;
        logic       uf;
        logic       zero;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       en = 1'b0;
    logic [3:0] step = '0;
    logic       auto_reload = 1'b0;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       underflow;
    logic       zero;

    obs_t w_cur;
    obs_t exp_q[$];
    obs_t act_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    decrement_counter #(.WIDTH(8), .STEP_W(4)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
        .stop(stop), .en(en), .step(step), .auto_reload(auto_reload),
        .count(count), .busy(busy), .done(done), .underflow(underflow), .zero(zero)
    );

    always #5 clk = ~clk;

    assign w_cur = {count, busy, done, underflow, zero};

    function automatic obs_t mk(input logic [7:0] c, input logic b, input logic d, input logic u);
        mk = {c, b, d, u, (c == 8'h00)};
    endfunction

    // Apply inputs for one cycle, queue the expected post-edge outputs, capture actuals.
    task automatic drive(input logic ld, input logic [7:0] lv, input logic st, input logic sp,
                         input logic e, input logic [3:0] stp, input logic ar, input obs_t ex);
        load = ld; load_val = lv; start = st; stop = sp; en = e; step = stp; auto_reload = ar;
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        act_q.push_back(w_cur);
    endtask

    task automatic idle(input obs_t ex);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, ex);
    endtask

    task automatic test_reset();
        obs_t e, a;
        #1;
        exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0));
        act_q.push_back(w_cur);
        drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0));
        rst = 1'b0;
        idle(mk(8'h00, 1'b0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL reset: got %h want %h", a, e);
            end
        end
    endtask

    task automatic test_start_zero();
        obs_t e, a;
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, mk(8'h00, 1'b0, 1'b1, 1'b0));
        idle(mk(8'h00, 1'b0, 1'b0, 1'b0));
        idle(mk(8'h00, 1'b0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL start_zero: got %h want %h", a, e);
            end
        end
    endtask

    task automatic test_oneshot();
        obs_t e, a;
        drive(1'b1, 8'h3F, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, mk(8'h3F, 1'b0, 1'b0, 1'b0));
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, mk(8'h3F, 1'b1, 1'b0, 1'b0));
        for (int i = 1; i <= 63; i++) begin
            if (i < 63)
                drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, mk(8'(63 - i), 1'b1, 1'b0, 1'b0));
            else
                drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, mk(8'h00, 1'b0, 1'b1, 1'b0));
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL oneshot: got %h want %h", a, e);
            end
        end
    endtask

    task automatic test_underflow();
        obs_t e, a;
        drive(1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, mk(8'd12, 1'b0, 1'b0, 1'b0));
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, mk(8'd12, 1'b1, 1'b0, 1'b0));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, mk(8'd7, 1'b1, 1'b0, 1'b0));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, mk(8'd2, 1'b1, 1'b0, 1'b0));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, mk(8'd0, 1'b0, 1'b1, 1'b1));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, mk(8'd0, 1'b0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL underflow: got %h want %h", a, e);
            end
        end
    endtask

    task automatic test_reload();
        obs_t e, a;
        drive(1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, mk(8'd4, 1'b0, 1'b0, 1'b0));
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, mk(8'd4, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, mk(8'd2, 1'b1, 1'b0, 1'b0));
            else
                drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, mk(8'd4, 1'b1, 1'b1, 1'b0));
        end
        // en with step 0 is a no-op, and start is ignored in RUN
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, mk(8'd4, 1'b1, 1'b0, 1'b0));
        // auto_reload dropped before the next terminal tick ends the run
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, mk(8'd2, 1'b1, 1'b0, 1'b0));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, mk(8'd0, 1'b0, 1'b1, 1'b1));
        idle(mk(8'd0, 1'b0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL reload: got %h want %h", a, e);
            end
        end
    endtask

    task automatic test_reload_zero();
        obs_t e, a;
        // load together with start: the loaded value decides RUN vs DONE
        drive(1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, mk(8'd3, 1'b1, 1'b0, 1'b0));
        // load beats stop and en while running
        drive(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, mk(8'd0, 1'b1, 1'b0, 1'b0));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, mk(8'd0, 1'b0, 1'b1, 1'b1));
        idle(mk(8'd0, 1'b0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL reload_zero: got %h want %h", a, e);
            end
        end
    endtask

    task automatic test_stop();
        obs_t e, a;
        drive(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, mk(8'h10, 1'b0, 1'b0, 1'b0));
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, mk(8'h10, 1'b1, 1'b0, 1'b0));
        for (int i = 1; i <= 3; i++)
            drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, mk(8'(16 - i), 1'b1, 1'b0, 1'b0));
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, mk(8'd13, 1'b0, 1'b0, 1'b0));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, mk(8'd13, 1'b0, 1'b0, 1'b0));
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, mk(8'd13, 1'b1, 1'b0, 1'b0));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, mk(8'd12, 1'b1, 1'b0, 1'b0));
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, mk(8'd12, 1'b0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL stop: got %h want %h", a, e);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t e, a;
        drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, mk(8'h22, 1'b0, 1'b0, 1'b0));
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, mk(8'h22, 1'b1, 1'b0, 1'b0));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, mk(8'h21, 1'b1, 1'b0, 1'b0));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, mk(8'h20, 1'b1, 1'b0, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0));
        act_q.push_back(w_cur);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0));
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0));
        idle(mk(8'h00, 1'b0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL async_reset: got %h want %h", a, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_zero();
        test_oneshot();
        test_underflow();
        test_reload();
        test_reload_zero();
        test_stop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decrement_counter.md
DECREMENT_COUNTER -- requirements
Module: decrement_counter

Interface
REQ-001 Parameter WIDTH, default 8: width of the count, load and reload values.
REQ-002 Parameter STEP_W, default 4: width of the step input; STEP_W SHALL be <= WIDTH.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 load  input  1  loads load_val into count and the reload register.
REQ-006 load_val  input  WIDTH  value captured on load.
REQ-007 start  input  1  begins counting (honoured in IDLE only).
REQ-008 stop  input  1  abort; returns to IDLE and holds count.
REQ-009 en  input  1  decrement tick qualifier (honoured in RUN only).
REQ-010 step  input  STEP_W  amount subtracted per tick, unsigned.
REQ-011 auto_reload  input  1  0 = one-shot saturating mode, 1 = periodic reload mode.
REQ-012 count  output  WIDTH  current registered count.
REQ-013 busy  output  1  high while the FSM is in RUN.
REQ-014 done  output  1  registered pulse, exactly one cycle per terminal event.
REQ-015 underflow  output  1  registered pulse on a tick where step > count.
REQ-016 zero  output  1  combinational, high when count == 0.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN and DONE, encoded as 2 bits.
REQ-018 IDLE behaviour SHALL be:
- count holds.
- start with the effective count != 0 -> RUN.
- start with the effective count == 0 -> DONE.
- Effective count = load_val if load is high in the same cycle, else count.
REQ-019 In RUN, the per-cycle priority SHALL be load > stop > en, with only the highest-priority active input taking effect.
REQ-020 load in RUN SHALL update count and the reload register, and the FSM SHALL stay in RUN.
REQ-021 stop in RUN SHALL move the FSM to IDLE with count unchanged, and done SHALL NOT assert.
REQ-022 In RUN with en=1 and step=0, the design SHALL do nothing: count unchanged, no flags.
REQ-023 In RUN with en=1 and step < count, count SHALL become count - step on the next edge.
REQ-024 In RUN with en=1, step >= count and auto_reload=0:
- count <- 0.
- FSM -> DONE.
- underflow pulses if step > count.
REQ-025 In RUN with en=1, step >= count and auto_reload=1:
- count <- reload register.
- done pulses on the next cycle.
- underflow pulses if step > count.
- FSM stays in RUN.
REQ-026 In RUN with auto_reload=1 and reload register = 0, the terminal tick SHALL pulse done, set count to 0 and move the FSM to DONE, so the counter does not hang.
REQ-027 The DONE state SHALL last one cycle, assert done, and then go to IDLE.
REQ-028 done and underflow SHALL be registered and SHALL be high only in the cycle after the causing edge.
REQ-029 Step arithmetic SHALL zero-extend step to WIDTH; the subtraction SHALL never wrap below 0.
REQ-030 In IDLE and DONE, en and step SHALL be ignored.
REQ-031 start in RUN or DONE SHALL be ignored.
REQ-032 auto_reload SHALL be sampled on every terminal tick; changing it mid-count affects only the next terminal tick.

Reset
REQ-033 On rst=1, immediately and independent of clk:
- FSM <- IDLE.
- count <- 0 and the reload register <- 0.
- busy, done and underflow <- 0.
- zero = 1.
REQ-034 Asserting rst mid-RUN SHALL abort counting with no done pulse; the first edge after deassertion SHALL evaluate from IDLE.

Verification
REQ-035 WIDTH=8: rst, then load 0x3F, start, en=1, step=1, auto_reload=0 -> count decrements 63..0 over 63 ticks; done pulses once; busy falls; underflow never asserts.
REQ-036 load 0x0C, start, step=5, auto_reload=0 -> count 12, 7, 2, 0; underflow pulses on the 2->0 tick together with done.
REQ-037 load 0x04, start, step=2, auto_reload=1 -> count 4, 2, 4, 2, 4...; done pulses every second tick; busy stays high; underflow stays 0.
REQ-038 load 0x10, start, 3 ticks of step=1, then stop and en together -> count holds 13; FSM goes to IDLE; done stays 0; a later start resumes from 13.
REQ-039 Mid-RUN at count 0x20, assert rst asynchronously between clock edges -> count=0, busy=0, zero=1 before the next edge; no done pulse.
REQ-040 start with count=0 in IDLE -> done pulses one cycle later; busy never asserts; count stays 0.
